// File: rtl/idli_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | idli_pkg : shared types and constants for the SQI SRAM sequencer      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package idli_pkg;

  typedef enum logic [2:0] {
    SQI_IDLE    = 3'd0,
    SQI_CS_HIGH = 3'd1,
    SQI_CMD     = 3'd2,
    SQI_ADDR    = 3'd3,
    SQI_DUMMY   = 3'd4,
    SQI_DATA    = 3'd5
  } sqi_state_t;

  localparam logic [7:0] SQI_CMD_READ      = 8'h03;
  localparam logic [7:0] SQI_CMD_WRITE     = 8'h02;
  localparam int         SQI_CMD_NIBBLES   = 2;
  localparam int         SQI_ADDR_NIBBLES  = 6;
  localparam int         SQI_DUMMY_NIBBLES = 2;

endpackage
`default_nettype wire

// File: rtl/idli_sqi_ctrl_m.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | idli_sqi_ctrl_m : SQI SRAM command/address/dummy/data sequencer       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module idli_sqi_ctrl_m
  import idli_pkg::*;
(
  input  logic        i_sqi_gck,
  input  logic        i_sqi_rst_n,
  input  logic        i_sqi_redirect,
  input  logic        i_sqi_wr,
  input  logic [15:0] i_sqi_addr,
  input  logic        i_sqi_stall,
  input  logic [3:0]  i_sqi_wdata,
  input  logic [3:0]  i_sqi_sio_in,
  output logic        o_sqi_cs_n,
  output logic        o_sqi_sck_en,
  output logic [3:0]  o_sqi_sio_out,
  output logic        o_sqi_sio_oe,
  output logic [3:0]  o_sqi_rdata,
  output logic        o_sqi_rdata_vld,
  output logic        o_sqi_wdata_rdy
);

  sqi_state_t  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] word_q, word_d;

  logic [2:0]  nib_idx;
  logic [3:0]  nib;
  logic        in_setup;
  logic        in_data;

  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      state_q <= SQI_IDLE;
      cnt_q   <= 3'd0;
      wr_q    <= 1'b0;
      word_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      word_q  <= word_d;
    end
  end

  // Redirect pre-empts every state, including CS_HIGH itself.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    word_d  = word_q;
    if (i_sqi_redirect) begin
      state_d = SQI_CS_HIGH;
      cnt_d   = 3'd0;
      wr_d    = i_sqi_wr;
      word_d  = {(i_sqi_wr ? SQI_CMD_WRITE : SQI_CMD_READ), 8'h00, i_sqi_addr};
    end else begin
      case (state_q)
        SQI_IDLE: ;
        SQI_CS_HIGH: begin
          state_d = SQI_CMD;
          cnt_d   = 3'd0;
        end
        SQI_CMD: begin
          if (cnt_q == 3'(SQI_CMD_NIBBLES - 1)) begin
            state_d = SQI_ADDR;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        SQI_ADDR: begin
          if (cnt_q == 3'(SQI_ADDR_NIBBLES - 1)) begin
            state_d = wr_q ? SQI_DATA : SQI_DUMMY;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        SQI_DUMMY: begin
          if (cnt_q == 3'(SQI_DUMMY_NIBBLES - 1)) begin
            state_d = SQI_DATA;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        SQI_DATA: ;
        default: begin
          state_d = SQI_IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  // Word layout is {cmd, 8'h00, addr}: ADDR nibbles follow the two CMD nibbles.
  assign nib_idx = (state_q == SQI_ADDR) ? (cnt_q + 3'(SQI_CMD_NIBBLES)) : cnt_q;

  always_comb begin
    nib = 4'd0;
    case (nib_idx)
      3'd0: nib = word_q[31:28];
      3'd1: nib = word_q[27:24];
      3'd2: nib = word_q[23:20];
      3'd3: nib = word_q[19:16];
      3'd4: nib = word_q[15:12];
      3'd5: nib = word_q[11:8];
      3'd6: nib = word_q[7:4];
      3'd7: nib = word_q[3:0];
      default: nib = 4'd0;
    endcase
  end

  assign in_setup = (state_q == SQI_CMD) || (state_q == SQI_ADDR);
  assign in_data  = (state_q == SQI_DATA);

  assign o_sqi_cs_n      = (state_q == SQI_IDLE) || (state_q == SQI_CS_HIGH);
  assign o_sqi_sck_en    = !o_sqi_cs_n && !(in_data && i_sqi_stall);
  assign o_sqi_sio_oe    = in_setup || (in_data && wr_q);
  assign o_sqi_sio_out   = in_setup            ? nib :
                           (in_data && wr_q)   ? i_sqi_wdata : 4'd0;
  assign o_sqi_rdata     = i_sqi_sio_in;
  assign o_sqi_rdata_vld = in_data && !wr_q && !i_sqi_stall;
  assign o_sqi_wdata_rdy = in_data && wr_q && !i_sqi_stall;

endmodule
`default_nettype wire

// File: tb/tb_idli_sqi_ctrl_m.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_idli_sqi_ctrl_m : randomized bench with cycle-count reference model|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_idli_sqi_ctrl_m;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect, wr, stall;
  logic [15:0] addr;
  logic [3:0]  wdata, sio_in;

  logic        cs_n, sck_en, sio_oe, rdata_vld, wdata_rdy;
  logic [3:0]  sio_out, rdata;

  always #5 clk = ~clk;

  idli_sqi_ctrl_m dut (
    .i_sqi_gck       (clk),
    .i_sqi_rst_n     (rst_n),
    .i_sqi_redirect  (redirect),
    .i_sqi_wr        (wr),
    .i_sqi_addr      (addr),
    .i_sqi_stall     (stall),
    .i_sqi_wdata     (wdata),
    .i_sqi_sio_in    (sio_in),
    .o_sqi_cs_n      (cs_n),
    .o_sqi_sck_en    (sck_en),
    .o_sqi_sio_out   (sio_out),
    .o_sqi_sio_oe    (sio_oe),
    .o_sqi_rdata     (rdata),
    .o_sqi_rdata_vld (rdata_vld),
    .o_sqi_wdata_rdy (wdata_rdy)
  );

  logic [14:0] obs;
  assign obs = {cs_n, sck_en, sio_oe, sio_out, rdata_vld, wdata_rdy, rdata};

  int n_checks = 0;
  int n_fail   = 0;

  // Model: m_k counts cycles since the redirect edge (1 = deselect cycle).
  logic        m_active = 1'b0;
  int          m_k = 0;
  logic        m_wr = 1'b0;
  logic [15:0] m_addr = 16'd0;
  logic [14:0] exp_v;

  function automatic logic [14:0] model_out();
    logic       setup, data, sel;
    logic [3:0] nib, out;
    int         n, cmd;
    setup = m_active && (m_k >= 2) && (m_k <= 9);
    data  = m_active && (m_wr ? (m_k >= 10) : (m_k >= 12));
    sel   = m_active && (m_k >= 2);
    nib   = 4'd0;
    if (setup) begin
      n   = m_k - 2;
      cmd = m_wr ? 2 : 3;
      if (n < 2)      nib = 4'((cmd >> (4 * (1 - n))) & 15);
      else if (n < 4) nib = 4'd0;
      else            nib = 4'((int'(m_addr) >> (4 * (7 - n))) & 15);
    end
    out = setup ? nib : ((data && m_wr) ? wdata : 4'd0);
    return {!sel, sel && !(data && stall), setup || (data && m_wr), out,
            data && !m_wr && !stall, data && m_wr && !stall, sio_in};
  endfunction

  task automatic drive(input logic rd, input logic w, input logic [15:0] a,
                       input logic st, input logic [3:0] wd, input logic [3:0] si);
    redirect = rd; wr = w; addr = a; stall = st; wdata = wd; sio_in = si;
    #3;
    exp_v = model_out();
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst_n) m_active = 1'b0;
    else if (redirect) begin
      m_active = 1'b1; m_k = 1; m_wr = wr; m_addr = addr;
    end else if (m_active && m_k < 1000) m_k++;
    #1;
  endtask

  function automatic logic [3:0] rn();
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), rn(), rn());
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL reset cyc %0d: got %h expected %h", i, obs, exp_v);
      end
      advance();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), rn(), rn());
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL idle cyc %0d: got %h expected %h", i, obs, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_read();
    drive(1'b1, 1'b0, 16'h1234, 1'b0, rn(), rn());
    advance();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 1'b0, rn(), (i == 11) ? 4'hA : rn());
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL read cyc %0d: got %h expected %h", i, obs, exp_v);
      end
      if (i == 11) begin
        n_checks++;
        if ({rdata_vld, rdata, sio_oe} !== 6'b1_1010_0) begin
          n_fail++; $display("FAIL read_first_data: got vld=%b rdata=%h oe=%b expected 1 a 0", rdata_vld, rdata, sio_oe);
        end
      end
      advance();
    end
  endtask

  task automatic test_write();
    drive(1'b1, 1'b1, 16'hBEEF, 1'b0, rn(), rn());
    advance();
    for (int i = 0; i < 14; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 1'b0, (i == 9) ? 4'h5 : rn(), rn());
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL write cyc %0d: got %h expected %h", i, obs, exp_v);
      end
      if (i == 9) begin
        n_checks++;
        if ({wdata_rdy, sio_out, sio_oe} !== 6'b1_0101_1) begin
          n_fail++; $display("FAIL write_first_data: got rdy=%b out=%h oe=%b expected 1 5 1", wdata_rdy, sio_out, sio_oe);
        end
      end
      advance();
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b0, 16'($urandom), 1'b0, rn(), rn());
    advance();
    for (int i = 0; i < 20; i++) begin
      // stall during setup must be ignored; stall in DATA at i=13..15
      drive(1'b0, 1'b0, 16'd0, (i < 11) ? 1'($urandom_range(0, 1)) : (i >= 13 && i <= 15), rn(), rn());
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL stall cyc %0d: got %h expected %h", i, obs, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_redirect_mid();
    drive(1'b1, 1'b0, 16'h5A5A, 1'b0, rn(), rn());
    advance();
    for (int i = 0; i < 22; i++) begin
      if (i == 5) drive(1'b1, 1'b0, 16'hC3E1, 1'b1, rn(), rn());
      else        drive(1'b0, 1'b1, 16'($urandom), 1'($urandom_range(0, 1)), rn(), rn());
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL redirect_mid cyc %0d: got %h expected %h", i, obs, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 16'($urandom), 1'b0, rn(), rn());
    advance();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b0, 16'd0, 1'b0, rn(), rn());
      advance();
    end
    drive(1'b0, 1'b0, 16'd0, 1'b0, rn(), rn());
    rst_n = 1'b0;
    #1;
    m_active = 1'b0;
    exp_v = model_out();
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL async_reset: got %h expected %h", obs, exp_v);
    end
    advance();
    drive(1'b1, 1'b1, 16'hFFFF, 1'b0, rn(), rn());
    advance();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), rn(), rn());
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL post_reset_idle cyc %0d: got %h expected %h", i, obs, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)), 16'($urandom),
            $urandom_range(0, 2) == 0, rn(), rn());
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL random cyc %0d: got %h expected %h", i, obs, exp_v);
      end
      advance();
    end
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; wr = 1'b0; addr = 16'd0;
    stall = 1'b0; wdata = 4'd0; sio_in = 4'd0;
    test_reset();
    test_read();
    test_write();
    test_stall();
    test_redirect_mid();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
